// File: rtl/pipelined_mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package pipelined_mips_fetch_pkg;

   localparam logic [31:0] MIPS_NOP               = 32'h0000_0000;
   localparam int          MIPS_FETCH_STATE_WIDTH = 2;

   typedef enum logic [MIPS_FETCH_STATE_WIDTH-1:0] {
      MIPS_FETCH_STATE_IDLE    = 2'd0,
      MIPS_FETCH_STATE_WAIT    = 2'd1,
      MIPS_FETCH_STATE_DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] pc_plus4;
   } ifid_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/pipelined_mips_fetch_if.sv
// Instruction-memory handshake plus the decode/EX control and IF/ID outputs of the fetch stage.
interface pipelined_mips_fetch_if;

   logic [31:0] o_imem_addr;
   logic        o_imem_req;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_stall;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic [31:0] o_instruction;
   logic [31:0] o_pc_plus4;
   logic        o_valid;

   modport master (
      output o_imem_addr, o_imem_req, o_instruction, o_pc_plus4, o_valid,
      input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_stall, i_redirect, i_redirect_pc
   );

   modport slave (
      input  o_imem_addr, o_imem_req, o_instruction, o_pc_plus4, o_valid,
      output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_stall, i_redirect, i_redirect_pc
   );

endinterface

// File: rtl/pipelined_mips_fetch_hold.sv
// One-entry skid buffer catching a response that arrives while decode is stalled.
// Registered; clear beats load, load beats drain.
module pipelined_mips_fetch_hold
   import pipelined_mips_fetch_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_reset_n,
   input  logic  i_load,
   input  ifid_t i_data,
   input  logic  i_drain,
   input  logic  i_clear,
   output logic  o_valid,
   output ifid_t o_data
);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (i_clear) begin
         o_valid <= 1'b0;
      end else if (i_load) begin
         o_valid <= 1'b1;
         o_data  <= i_data;
      end else if (i_drain) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipelined_mips_fetch.sv
// Fetch stage: owns the PC, issues one imem read at a time, drives IF/ID (gnt->rvalid->IF/ID, 2 cycles).
// Decode stall holds IF/ID and parks one response in the hold buffer; redirect flushes everything.
module pipelined_mips_fetch
   import pipelined_mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                    i_clk,
   input logic                    i_reset_n,
   pipelined_mips_fetch_if.master bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc;
   logic [31:0]  req_pc;
   ifid_t        ifid_q;
   logic         valid_q;
   logic         imem_req;
   logic         fire;
   logic         rsp;
   logic         accept;
   logic         hold_valid;
   logic         hold_load;
   logic         hold_drain;
   ifid_t        hold_data;
   ifid_t        rsp_data;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= MIPS_FETCH_STATE_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      case (state_q)
         MIPS_FETCH_STATE_IDLE: begin
            imem_req = !hold_valid && !bus.i_redirect;
            if (imem_req && bus.i_imem_gnt) state_d = MIPS_FETCH_STATE_WAIT;
         end
         MIPS_FETCH_STATE_WAIT: begin
            // A redirect with no response yet must still swallow the one in flight.
            if (bus.i_imem_rvalid)   state_d = MIPS_FETCH_STATE_IDLE;
            else if (bus.i_redirect) state_d = MIPS_FETCH_STATE_DISCARD;
         end
         MIPS_FETCH_STATE_DISCARD: begin
            if (bus.i_imem_rvalid) state_d = MIPS_FETCH_STATE_IDLE;
         end
         default: state_d = MIPS_FETCH_STATE_IDLE;
      endcase
   end

   assign fire       = imem_req && bus.i_imem_gnt;
   assign rsp        = (state_q == MIPS_FETCH_STATE_WAIT) && bus.i_imem_rvalid && !bus.i_redirect;
   assign accept     = !bus.i_stall || !valid_q;
   assign hold_load  = rsp && !accept;
   assign hold_drain = hold_valid && !bus.i_stall;
   assign rsp_data   = '{instruction: bus.i_imem_rdata, pc_plus4: req_pc + 32'd4};

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         fetch_pc <= align_pc(RESET_PC);
         req_pc   <= '0;
      end else if (bus.i_redirect) begin
         fetch_pc <= align_pc(bus.i_redirect_pc);
      end else if (fire) begin
         req_pc   <= fetch_pc;
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         valid_q <= 1'b0;
         ifid_q  <= '0;
      end else if (bus.i_redirect) begin
         valid_q            <= 1'b0;
         ifid_q.instruction <= MIPS_NOP;
      end else if (hold_drain) begin
         valid_q <= 1'b1;
         ifid_q  <= hold_data;
      end else if (rsp && accept) begin
         valid_q <= 1'b1;
         ifid_q  <= rsp_data;
      end else if (!bus.i_stall) begin
         valid_q            <= 1'b0;
         ifid_q.instruction <= MIPS_NOP;
      end
   end

   pipelined_mips_fetch_hold u_hold (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_load    (hold_load),
      .i_data    (rsp_data),
      .i_drain   (hold_drain),
      .i_clear   (bus.i_redirect),
      .o_valid   (hold_valid),
      .o_data    (hold_data)
   );

   assign bus.o_imem_req    = imem_req;
   assign bus.o_imem_addr   = fetch_pc;
   assign bus.o_instruction = ifid_q.instruction;
   assign bus.o_pc_plus4    = ifid_q.pc_plus4;
   assign bus.o_valid       = valid_q;

endmodule

// File: doc/pipelined_mips_fetch.md
# pipelined_mips_fetch

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter and issues one word-aligned read at a time to instruction memory over a request/grant/response handshake. It absorbs variable memory latency and drives the IF/ID pipeline register whose instruction word feeds the control decoder. It honours decode-side stalls and EX-side branch/jump redirects, and discards stale responses after a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `i_clk`  in  1  core clock; all state updates on the rising edge.
- `i_reset_n`  in  1  reset, asynchronous and active-low.
- `o_imem_addr`  out  32  byte address of the current request; bits [1:0] always 0.
- `o_imem_req`  out  1  request valid.
- `i_imem_gnt`  in  1  memory accepts the request this cycle.
- `i_imem_rvalid`  in  1  read data valid.
- `i_imem_rdata`  in  32  read data.
- `i_stall`  in  1  decode cannot accept; IF/ID must hold.
- `i_redirect`  in  1  taken branch/jump; abandon the sequential stream.
- `i_redirect_pc`  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- `o_instruction`  out  32  IF/ID instruction word, consumed by the control decoder.
- `o_pc_plus4`  out  32  IF/ID PC+4 of that instruction.
- `o_valid`  out  1  IF/ID holds a real instruction.

## Operation
- **State machine** (3 states):
  - IDLE: no request outstanding.
  - WAIT: request accepted, response pending.
  - DISCARD: the pending response belongs to an abandoned path.
- **Request:** `o_imem_req` = (state==IDLE) && !hold_valid && !i_redirect. `o_imem_addr` = fetch_pc.
- **Grant:** on `o_imem_req && i_imem_gnt`:
  - req_pc <= fetch_pc.
  - fetch_pc <= fetch_pc+4, modulo 2^32 (wraps to 0).
  - State goes to WAIT.
- **WAIT, `i_imem_rvalid`:** state goes to IDLE.
  - If IF/ID can accept (!i_stall || !o_valid): IF/ID <= {rdata, req_pc+4, valid=1}.
  - Otherwise the one-entry hold buffer captures {rdata, req_pc+4}.
  - At most one request is outstanding; rvalid in IDLE is ignored.
- **IF/ID update when !i_stall** (priority order):
  1. hold_valid: load the hold buffer and clear hold_valid.
  2. rvalid in WAIT: load the response.
  3. Otherwise load a bubble: valid=0, instruction=`MIPS_NOP (32'h0), pc_plus4 unchanged.
- **i_stall:** IF/ID holds all fields. Fetch continues until the hold buffer is full.
- **Redirect** (beats stall and everything else):
  - fetch_pc <= {i_redirect_pc[31:2],2'b00}.
  - IF/ID flushed: valid=0, instruction=NOP.
  - hold_valid cleared.
  - In WAIT: goes to DISCARD without rvalid; with rvalid that cycle, the data is dropped and state goes to IDLE.
  - In DISCARD: fetch_pc is updated and the state stays DISCARD.
  - No request is issued in the redirect cycle.
- **DISCARD, `i_imem_rvalid`:** data dropped, state goes to IDLE.

## Timing
- **Reset** (async, immediate):
  - state=IDLE, fetch_pc=RESET_PC, hold_valid=0.
  - o_valid=0, o_instruction=32'h0, o_pc_plus4=32'h0.
  - o_imem_req=1 from the first cycle after reset deasserts.
- **Reset mid-operation:** an outstanding response is forgotten; rvalid arriving in IDLE is ignored.
- **Latency:** with gnt in cycle N and rvalid in cycle N+1, the instruction is on `o_instruction` with o_valid=1 in cycle N+2.
- **Throughput:** peak is one instruction per 2 cycles (request, then response). An extra memory wait cycle adds one cycle.
- **Redirect:** asserted in cycle N, the next request to the redirect PC is in cycle N+1, or after the discarded response returns.
- **Outputs:** all registered except `o_imem_req`/`o_imem_addr`. `o_imem_req` has a combinational path from `i_redirect`.

## Structure
- `constants.vh` gains:
  - `MIPS_NOP` = 32'h0.
  - `MIPS_FETCH_STATE_IDLE/WAIT/DISCARD` (2-bit encodings).
  - `MIPS_FETCH_STATE_WIDTH`.
- One sub-module is natural: `pipelined_mips_fetch_hold`, the one-entry 64-bit hold buffer with load/drain/clear. All other logic lives in the top module.

## Test plan
- **Reset, then sequential fetch:** RESET_PC=0, gnt always 1, rvalid the cycle after gnt. Expect requests to 0,4,8, and o_valid with pc_plus4=4,8,12 on alternating cycles.
- **Stall with hold:** stall asserted while the response for PC 8 returns.
  - Expect IF/ID held and the hold buffer filled.
  - Expect no new request until the stall drops.
  - Then pc_plus4=12 is presented, and the request to 12 issues after the hold buffer drains.
- **Redirect during WAIT:** redirect to 32'h40 while WAIT; the stale rvalid two cycles later (rdata 32'hDEAD_BEEF).
  - Expect rdata never reaches IF/ID.
  - Expect the next request address to be 32'h40.
- **Redirect and stall in the same cycle:** expect o_valid=0 and o_instruction=0 the next cycle.
- **Misaligned redirect plus wrap:** redirect to 32'hFFFF_FFFE. Expect a request to 32'hFFFF_FFFC, then 32'h0000_0000.
- **Reset asserted mid-WAIT:** outputs clear immediately; a late rvalid is ignored; the first request after reset goes to RESET_PC.
